// File: rtl/rgb_gray_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rgb_gray_stream                                                 |
// | Brief    : 3-stage valid/ready RGB-to-grayscale converter with sof/eof      |
// |            framing, per-frame mode latch and saturating drop counter.       |
// |            Optional macro GRAY_ROUND_EN selects round-half-up in modes 0/1. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rgb_gray_stream #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int R_COEF = 77,
    parameter int G_COEF = 150,
    parameter int B_COEF = 29,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] red_i,
    input  logic [DATA_W-1:0] green_i,
    input  logic [DATA_W-1:0] blue_i,
    input  logic              sof_i,
    input  logic              eof_i,
    input  logic [1:0]        mode_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] gray_o,
    output logic              sof_o,
    output logic              eof_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    localparam int c_PROD_W = DATA_W + COEF_W;
    localparam int c_SUM_W  = DATA_W + COEF_W + 2;
    localparam int c_FAST_W = DATA_W + 2;

    localparam logic [COEF_W-1:0] c_R_COEF = COEF_W'(R_COEF);
    localparam logic [COEF_W-1:0] c_G_COEF = COEF_W'(G_COEF);
    localparam logic [COEF_W-1:0] c_B_COEF = COEF_W'(B_COEF);
    localparam logic [DATA_W-1:0] c_MAX    = '1;

`ifdef GRAY_ROUND_EN
    localparam logic [c_SUM_W-1:0]  c_W_RND = c_SUM_W'(1) << (COEF_W - 1);
    localparam logic [c_FAST_W-1:0] c_F_RND = c_FAST_W'(2);
`else
    localparam logic [c_SUM_W-1:0]  c_W_RND = '0;
    localparam logic [c_FAST_W-1:0] c_F_RND = '0;
`endif

    localparam logic [1:0] c_MODE_WEIGHTED = 2'd0;
    localparam logic [1:0] c_MODE_FAST     = 2'd1;
    localparam logic [1:0] c_MODE_GREEN    = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             w_en;
    logic             w_accept;
    logic             w_fwd;
    logic             w_drop;

    // Stage 1: captured pixel
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_r;
    logic [DATA_W-1:0] r_s1_g;
    logic [DATA_W-1:0] r_s1_b;
    logic [1:0]        r_s1_mode;
    logic              r_s1_sof;
    logic              r_s1_eof;

    // Stage 2: weighted products or the finished non-weighted result
    logic                r_s2_valid;
    logic [c_PROD_W-1:0] r_s2_pr;
    logic [c_PROD_W-1:0] r_s2_pg;
    logic [c_PROD_W-1:0] r_s2_pb;
    logic [DATA_W-1:0]   r_s2_alt;
    logic                r_s2_weighted;
    logic                r_s2_sof;
    logic                r_s2_eof;

    // Stage 3: output register
    logic              r_s3_valid;
    logic [DATA_W-1:0] r_s3_gray;
    logic              r_s3_sof;
    logic              r_s3_eof;

    logic [c_PROD_W-1:0] w_pr;
    logic [c_PROD_W-1:0] w_pg;
    logic [c_PROD_W-1:0] w_pb;
    logic [c_FAST_W-1:0] w_fast_sum;
    logic [DATA_W-1:0]   w_fast;
    logic [DATA_W-1:0]   w_max_rg;
    logic [DATA_W-1:0]   w_max;
    logic [DATA_W-1:0]   w_alt;
    logic [c_SUM_W-1:0]  w_sum;
    logic [c_SUM_W-1:0]  w_shifted;
    logic [DATA_W-1:0]   w_weighted;
    logic [DATA_W-1:0]   w_gray;

    assign w_en       = !r_s3_valid || out_ready_i;
    assign in_ready_o = w_en || rst;
    assign w_accept   = in_valid_i && w_en && !rst;

    // Framing: decide per accepted beat whether it is forwarded or dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_fwd       = 1'b0;
        w_drop      = 1'b0;
        if (w_accept) begin
            if (sof_i) begin
                w_fwd       = 1'b1;
                w_mode_nxt  = mode_i;
                w_state_nxt = eof_i ? ST_IDLE : ST_ACTIVE;
            end else if (r_state == ST_ACTIVE) begin
                w_fwd = 1'b1;
                if (eof_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mode     <= 2'd0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_r     <= '0;
            r_s1_g     <= '0;
            r_s1_b     <= '0;
            r_s1_mode  <= 2'd0;
            r_s1_sof   <= 1'b0;
            r_s1_eof   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= w_fwd;
            r_s1_r     <= red_i;
            r_s1_g     <= green_i;
            r_s1_b     <= blue_i;
            r_s1_mode  <= w_mode_nxt;
            r_s1_sof   <= sof_i;
            r_s1_eof   <= eof_i;
        end
    end

    assign w_pr = c_PROD_W'(r_s1_r) * c_PROD_W'(c_R_COEF);
    assign w_pg = c_PROD_W'(r_s1_g) * c_PROD_W'(c_G_COEF);
    assign w_pb = c_PROD_W'(r_s1_b) * c_PROD_W'(c_B_COEF);

    assign w_fast_sum = c_FAST_W'(r_s1_r) + (c_FAST_W'(r_s1_g) << 1)
                      + c_FAST_W'(r_s1_b) + c_F_RND;
    assign w_fast     = DATA_W'(w_fast_sum >> 2);
    assign w_max_rg   = (r_s1_r > r_s1_g) ? r_s1_r : r_s1_g;
    assign w_max      = (w_max_rg > r_s1_b) ? w_max_rg : r_s1_b;

    always_comb begin
        w_alt = '0;
        case (r_s1_mode)
            c_MODE_FAST:  w_alt = w_fast;
            c_MODE_GREEN: w_alt = r_s1_g;
            default:      w_alt = w_max;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid    <= 1'b0;
            r_s2_pr       <= '0;
            r_s2_pg       <= '0;
            r_s2_pb       <= '0;
            r_s2_alt      <= '0;
            r_s2_weighted <= 1'b0;
            r_s2_sof      <= 1'b0;
            r_s2_eof      <= 1'b0;
        end else if (w_en) begin
            r_s2_valid    <= r_s1_valid;
            r_s2_pr       <= w_pr;
            r_s2_pg       <= w_pg;
            r_s2_pb       <= w_pb;
            r_s2_alt      <= w_alt;
            r_s2_weighted <= (r_s1_mode == c_MODE_WEIGHTED);
            r_s2_sof      <= r_s1_sof;
            r_s2_eof      <= r_s1_eof;
        end
    end

    // Oversized coefficient sets can push the weighted result past full scale.
    assign w_sum      = c_SUM_W'(r_s2_pr) + c_SUM_W'(r_s2_pg) + c_SUM_W'(r_s2_pb) + c_W_RND;
    assign w_shifted  = w_sum >> COEF_W;
    assign w_weighted = (w_shifted > c_SUM_W'(c_MAX)) ? c_MAX : DATA_W'(w_shifted);
    assign w_gray     = r_s2_weighted ? w_weighted : r_s2_alt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_s3_gray  <= '0;
            r_s3_sof   <= 1'b0;
            r_s3_eof   <= 1'b0;
        end else if (w_en) begin
            r_s3_valid <= r_s2_valid;
            r_s3_gray  <= w_gray;
            r_s3_sof   <= r_s2_sof;
            r_s3_eof   <= r_s2_eof;
        end
    end

    assign out_valid_o = r_s3_valid;
    assign gray_o      = r_s3_gray;
    assign sof_o       = r_s3_sof;
    assign eof_o       = r_s3_eof;
    assign drop_cnt_o  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rgb_gray_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rgb_gray_stream                                              |
// | Brief    : Directed bench for rgb_gray_stream; default DUT plus a CNT_W=2,  |
// |            all-128-coefficient DUT sharing the same stimulus.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rgb_gray_stream;

`ifdef GRAY_ROUND_EN
    localparam int W_RND    = 128;
    localparam int F_RND    = 2;
    localparam int EXP_RED0 = 77;
    localparam int EXP_RED1 = 128;
`else
    localparam int W_RND    = 0;
    localparam int F_RND    = 0;
    localparam int EXP_RED0 = 76;
    localparam int EXP_RED1 = 127;
`endif

    typedef struct {
        int r;
        int g;
        int b;
        int mode;
        bit sof;
        bit eof;
    } beat_t;

    logic       clk;
    logic       rst;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       sof_in;
    logic       eof_in;
    logic [1:0] mode;
    logic       in_valid;
    logic       out_ready;

    logic        in_ready0, in_ready1;
    logic [7:0]  gray0, gray1;
    logic        sof0, sof1, eof0, eof1;
    logic        out_valid0, out_valid1;
    logic [15:0] drop_cnt0;
    logic [1:0]  drop_cnt1;

    int checks = 0;
    int errors = 0;

    beat_t q0[$];
    beat_t q1[$];
    bit    in_frame = 0;
    int    cur_mode = 0;
    int    drop0 = 0;
    int    drop1 = 0;
    int    pops0 = 0;
    bit    prev_stall = 0;
    int    prev_gray = 0;

    rgb_gray_stream dut0 (
        .clk(clk), .rst(rst),
        .red_i(red), .green_i(green), .blue_i(blue),
        .sof_i(sof_in), .eof_i(eof_in), .mode_i(mode),
        .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .gray_o(gray0), .sof_o(sof0), .eof_o(eof0),
        .out_valid_o(out_valid0), .out_ready_i(out_ready),
        .drop_cnt_o(drop_cnt0)
    );

    rgb_gray_stream #(
        .R_COEF(128), .G_COEF(128), .B_COEF(128), .CNT_W(2)
    ) dut1 (
        .clk(clk), .rst(rst),
        .red_i(red), .green_i(green), .blue_i(blue),
        .sof_i(sof_in), .eof_i(eof_in), .mode_i(mode),
        .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .gray_o(gray1), .sof_o(sof1), .eof_o(eof1),
        .out_valid_o(out_valid1), .out_ready_i(out_ready),
        .drop_cnt_o(drop_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_gray(beat_t b, int rc, int gc, int bc);
        int s;
        case (b.mode)
            0: begin
                s = (b.r * rc + b.g * gc + b.b * bc + W_RND) / 256;
                if (s > 255) s = 255;
            end
            1: s = (b.r + 2 * b.g + b.b + F_RND) / 4;
            2: s = b.g;
            default: begin
                s = b.r;
                if (b.g > s) s = b.g;
                if (b.b > s) s = b.b;
            end
        endcase
        return s;
    endfunction

    task automatic cmp_out(input string tag, ref beat_t q[$], input logic ov, input logic [7:0] g,
                           input logic so, input logic eo, input int rc, input int gc, input int bc);
        beat_t b;
        if (!ov) return;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected_out: got valid beat gray %0d expected none", tag, g);
            return;
        end
        b = q[0];
        chk({tag, "_gray"}, int'(g), exp_gray(b, rc, gc, bc));
        chk({tag, "_sof"}, int'(so), int'(b.sof));
        chk({tag, "_eof"}, int'(eo), int'(b.eof));
        if (out_ready) void'(q.pop_front());
    endtask

    // Reference model: framing rules on accepted beats, scoreboard on emitted beats.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            q0.delete();
            q1.delete();
            in_frame   = 0;
            cur_mode   = 0;
            drop0      = 0;
            drop1      = 0;
            prev_stall = 0;
        end else begin
            chk("in_ready0", int'(in_ready0), int'(!out_valid0 || out_ready));
            chk("in_ready1", int'(in_ready1), int'(!out_valid1 || out_ready));
            chk("drop_cnt0", int'(drop_cnt0), drop0);
            chk("drop_cnt1", int'(drop_cnt1), drop1);
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid0), 1);
                chk("hold_gray", int'(gray0), prev_gray);
            end
            if (out_valid0 && out_ready) pops0++;
            cmp_out("dut0", q0, out_valid0, gray0, sof0, eof0, 77, 150, 29);
            cmp_out("dut1", q1, out_valid1, gray1, sof1, eof1, 128, 128, 128);
            prev_stall = out_valid0 && !out_ready;
            prev_gray  = int'(gray0);
            if (in_valid && in_ready0) begin
                if (!in_frame && !sof_in) begin
                    if (drop0 < 65535) drop0++;
                    if (drop1 < 3) drop1++;
                end else begin
                    if (sof_in) cur_mode = int'(mode);
                    b.r = int'(red); b.g = int'(green); b.b = int'(blue);
                    b.mode = cur_mode; b.sof = sof_in; b.eof = eof_in;
                    q0.push_back(b);
                    q1.push_back(b);
                    in_frame = !eof_in;
                end
            end
        end
    end

    task automatic send_beat(input int r, input int g, input int b, input int m,
                             input bit s, input bit e);
        bit hs = 0;
        red = 8'(r); green = 8'(g); blue = 8'(b); mode = 2'(m);
        sof_in = s; eof_in = e; in_valid = 1'b1;
        for (int i = 0; i < 64 && !hs; i++) begin
            @(negedge clk);
            hs = in_ready0;
            @(posedge clk);
            #1;
        end
        if (!hs) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One isolated beat with literal expectations and exact 3-cycle latency.
    task automatic pin(input string name, input int r, input int g, input int b, input int m,
                       input bit s, input bit e, input int e0, input int e1);
        send_beat(r, g, b, m, s, e);
        wait_cycles(1);
        chk({name, "_early_valid"}, int'(out_valid0), 0);
        wait_cycles(1);
        chk({name, "_valid"}, int'(out_valid0), 1);
        chk({name, "_gray0"}, int'(gray0), e0);
        chk({name, "_gray1"}, int'(gray1), e1);
        chk({name, "_sof"}, int'(sof0), int'(s));
        chk({name, "_eof"}, int'(eof0), int'(e));
        wait_cycles(1);
    endtask

    initial begin
        int p;
        rst = 1'b1; red = '0; green = '0; blue = '0; sof_in = 1'b0; eof_in = 1'b0;
        mode = 2'd0; in_valid = 1'b0; out_ready = 1'b1;
        wait_cycles(3);
        chk("rst_in_ready", int'(in_ready0), 1);
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_gray", int'(gray0), 0);
        chk("rst_sof_eof", int'({sof0, eof0}), 0);
        chk("rst_drop", int'(drop_cnt0), 0);
        rst = 1'b0;
        wait_cycles(1);

        for (int i = 0; i < 3; i++) send_beat(10 * i, 20, 30, 1, 0, i == 2);
        wait_cycles(5);
        chk("drop3_dut0", int'(drop_cnt0), 3);
        chk("drop3_dut1", int'(drop_cnt1), 3);
        send_beat(1, 2, 3, 0, 0, 0);
        wait_cycles(1);
        chk("drop4_dut0", int'(drop_cnt0), 4);
        chk("drop4_sat_dut1", int'(drop_cnt1), 3);

        pin("red_w", 255, 0, 0, 0, 1, 1, EXP_RED0, EXP_RED1);
        pin("white_w", 255, 255, 255, 0, 1, 1, 255, 255);
        pin("fast", 100, 50, 200, 1, 1, 1, 100, 100);
        pin("green", 100, 50, 200, 2, 1, 1, 50, 50);
        pin("max", 100, 50, 200, 3, 1, 1, 200, 200);
        pin("mid_sof", 100, 50, 200, 2, 1, 0, 50, 50);
        pin("mid_body", 100, 50, 200, 3, 0, 0, 50, 50);
        pin("mid_eof", 100, 50, 200, 3, 0, 1, 50, 50);
        pin("relatch", 100, 50, 200, 3, 1, 1, 200, 200);

        p = pops0;
        fork
            for (int i = 0; i < 8; i++)
                send_beat(20 * i + 5, 255 - 25 * i, 13 * i, 0, i == 0, i == 7);
            for (int c = 0; c < 40; c++) begin
                out_ready = (c % 4 == 0) || (c % 4 == 3);
                wait_cycles(1);
            end
        join
        out_ready = 1'b1;
        wait_cycles(5);
        chk("bp_out_count", pops0 - p, 8);
        chk("bp_queue_empty", q0.size(), 0);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(40 + i, 80, 120, 1, i == 0, 0);
        chk("pre_rst_valid", int'(out_valid0), 1);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_valid", int'(out_valid0), 0);
        p = pops0;
        wait_cycles(6);
        chk("post_rst_no_stale", pops0 - p, 0);
        send_beat(9, 9, 9, 0, 0, 0);
        wait_cycles(5);
        chk("post_rst_drop0", int'(drop_cnt0), 1);
        chk("post_rst_drop1", int'(drop_cnt1), 1);
        chk("post_rst_no_out", pops0 - p, 0);

        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
